// File: rtl/prog_timer_bus_regs_if.sv
// CPU bus bundle between the CPU and the timer register front end.
// The CPU drives address, strobes and write data; the register block
// answers with a registered read nibble and a one-cycle valid.
interface prog_timer_bus_regs_if;
    logic [11:0] bus_addr;
    logic        bus_write_en;
    logic [3:0]  bus_write_data;
    logic        bus_read_en;
    logic [3:0]  bus_read_data;
    logic        bus_read_valid;

    modport master (
        output bus_addr,
        output bus_write_en,
        output bus_write_data,
        output bus_read_en,
        input  bus_read_data,
        input  bus_read_valid
    );

    modport slave (
        input  bus_addr,
        input  bus_write_en,
        input  bus_write_data,
        input  bus_read_en,
        output bus_read_data,
        output bus_read_valid
    );
endinterface

// File: rtl/prog_timer_bus_regs.sv
// Register front end for the programmable timer.
// Decodes CPU nibble accesses into timer control (run, reload pulse, clock
// select, reload value), returns timer status with a coherent two-nibble
// count read and a clear-on-read factor flag, and registers the masked
// interrupt request.
module prog_timer_bus_regs #(
    parameter logic [11:0] ADDR_DATA_LO   = 12'hF24,
    parameter logic [11:0] ADDR_DATA_HI   = 12'hF25,
    parameter logic [11:0] ADDR_RELOAD_LO = 12'hF26,
    parameter logic [11:0] ADDR_RELOAD_HI = 12'hF27,
    parameter logic [11:0] ADDR_CTRL      = 12'hF78,
    parameter logic [11:0] ADDR_CLKSEL    = 12'hF79,
    parameter logic [11:0] ADDR_FACTOR    = 12'hF02,
    parameter logic [11:0] ADDR_MASK      = 12'hF12
) (
    input  logic                  clk,
    input  logic                  reset_n,
    prog_timer_bus_regs_if.slave  bus,
    output logic                  timer_enable,
    output logic                  timer_reset,
    output logic [2:0]            timer_clock_selection,
    output logic [7:0]            timer_counter_reload,
    output logic                  timer_reset_factor,
    input  logic                  timer_factor_flags,
    input  logic [7:0]            timer_downcounter,
    output logic                  interrupt_req
);

    logic [3:0] hi_latch;
    logic       mask;
    logic [3:0] read_next;

    // Read mux built from current register state, so a read that coincides
    // with a write to the same address returns the pre-write value.
    always_comb begin
        read_next = 4'h0;
        case (bus.bus_addr)
            ADDR_DATA_LO:   read_next = timer_downcounter[3:0];
            ADDR_DATA_HI:   read_next = hi_latch;
            ADDR_RELOAD_LO: read_next = timer_counter_reload[3:0];
            ADDR_RELOAD_HI: read_next = timer_counter_reload[7:4];
            ADDR_CTRL:      read_next = {3'b000, timer_enable};
            ADDR_CLKSEL:    read_next = {1'b0, timer_clock_selection};
            ADDR_FACTOR:    read_next = {3'b000, timer_factor_flags};
            ADDR_MASK:      read_next = {3'b000, mask};
            default:        read_next = 4'h0;
        endcase
    end

    // Register state, bus responses, one-cycle pulses and the interrupt.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            timer_enable          <= 1'b0;
            timer_reset           <= 1'b0;
            timer_clock_selection <= 3'b000;
            timer_counter_reload  <= 8'h00;
            timer_reset_factor    <= 1'b0;
            interrupt_req         <= 1'b0;
            hi_latch              <= 4'h0;
            mask                  <= 1'b0;
            bus.bus_read_data     <= 4'h0;
            bus.bus_read_valid    <= 1'b0;
        end else begin
            timer_reset        <= 1'b0;
            timer_reset_factor <= 1'b0;
            bus.bus_read_valid <= 1'b0;
            interrupt_req      <= timer_factor_flags & mask;

            if (bus.bus_read_en) begin
                bus.bus_read_data  <= read_next;
                bus.bus_read_valid <= 1'b1;
                // Capturing the upper nibble with the lower one keeps a
                // LO-then-HI read pair coherent while the timer counts.
                if (bus.bus_addr == ADDR_DATA_LO)
                    hi_latch <= timer_downcounter[7:4];
                // Only clear a flag the CPU actually saw as set.
                if (bus.bus_addr == ADDR_FACTOR && timer_factor_flags)
                    timer_reset_factor <= 1'b1;
            end

            if (bus.bus_write_en) begin
                case (bus.bus_addr)
                    ADDR_RELOAD_LO: timer_counter_reload[3:0] <= bus.bus_write_data;
                    ADDR_RELOAD_HI: timer_counter_reload[7:4] <= bus.bus_write_data;
                    ADDR_CTRL: begin
                        timer_enable <= bus.bus_write_data[0];
                        if (bus.bus_write_data[1])
                            timer_reset <= 1'b1;
                    end
                    ADDR_CLKSEL:    timer_clock_selection <= bus.bus_write_data[2:0];
                    ADDR_MASK:      mask <= bus.bus_write_data[0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_timer_bus_regs.sv
// Directed bench for the timer register front end.
module tb_prog_timer_bus_regs;

    localparam logic [11:0] A_DATA_LO   = 12'hF24;
    localparam logic [11:0] A_DATA_HI   = 12'hF25;
    localparam logic [11:0] A_RELOAD_LO = 12'hF26;
    localparam logic [11:0] A_RELOAD_HI = 12'hF27;
    localparam logic [11:0] A_CTRL      = 12'hF78;
    localparam logic [11:0] A_CLKSEL    = 12'hF79;
    localparam logic [11:0] A_FACTOR    = 12'hF02;
    localparam logic [11:0] A_MASK      = 12'hF12;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       timer_enable;
    logic       timer_reset;
    logic [2:0] timer_clock_selection;
    logic [7:0] timer_counter_reload;
    logic       timer_reset_factor;
    logic       timer_factor_flags;
    logic [7:0] timer_downcounter;
    logic       interrupt_req;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] rd;
    logic       rv;

    prog_timer_bus_regs_if bus ();

    prog_timer_bus_regs dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .bus                   (bus.slave),
        .timer_enable          (timer_enable),
        .timer_reset           (timer_reset),
        .timer_clock_selection (timer_clock_selection),
        .timer_counter_reload  (timer_counter_reload),
        .timer_reset_factor    (timer_reset_factor),
        .timer_factor_flags    (timer_factor_flags),
        .timer_downcounter     (timer_downcounter),
        .interrupt_req         (interrupt_req)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [11:0] a, input logic [3:0] d);
        @(negedge clk);
        bus.bus_addr       = a;
        bus.bus_write_data = d;
        bus.bus_write_en   = 1'b1;
        @(posedge clk);
        #1;
        bus.bus_write_en   = 1'b0;
    endtask

    task automatic do_read(input logic [11:0] a, output logic [3:0] d, output logic v);
        @(negedge clk);
        bus.bus_addr    = a;
        bus.bus_read_en = 1'b1;
        @(posedge clk);
        #1;
        d = bus.bus_read_data;
        v = bus.bus_read_valid;
        bus.bus_read_en = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [11:0] a, input logic [3:0] exp);
        logic [3:0] d;
        logic       v;
        do_read(a, d, v);
        check_val({tag, "_valid"}, {31'd0, v}, 32'd1);
        check_val(tag, {28'd0, d}, {28'd0, exp});
    endtask

    initial begin
        logic [11:0] addrs [9];
        addrs = '{A_DATA_LO, A_DATA_HI, A_RELOAD_LO, A_RELOAD_HI, A_CTRL,
                  A_CLKSEL, A_FACTOR, A_MASK, 12'h000};

        reset_n             = 1'b0;
        bus.bus_addr        = 12'h000;
        bus.bus_write_en    = 1'b0;
        bus.bus_write_data  = 4'h0;
        bus.bus_read_en     = 1'b0;
        timer_factor_flags  = 1'b0;
        timer_downcounter   = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_enable", {31'd0, timer_enable}, 32'd0);
        check_val("rst_treset", {31'd0, timer_reset}, 32'd0);
        check_val("rst_clksel", {29'd0, timer_clock_selection}, 32'd0);
        check_val("rst_reload", {24'd0, timer_counter_reload}, 32'd0);
        check_val("rst_rfactor", {31'd0, timer_reset_factor}, 32'd0);
        check_val("rst_irq", {31'd0, interrupt_req}, 32'd0);
        check_val("rst_valid", {31'd0, bus.bus_read_valid}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Every listed address plus one unlisted reads 0 with valid.
        for (int i = 0; i < 9; i++) begin
            read_check($sformatf("init_rd_%0h", addrs[i]), addrs[i], 4'h0);
            @(posedge clk);
            #1;
            check_val("valid_drop", {31'd0, bus.bus_read_valid}, 32'd0);
        end

        // Reload nibbles
        do_write(A_RELOAD_LO, 4'hA);
        do_write(A_RELOAD_HI, 4'h3);
        check_val("reload_3A", {24'd0, timer_counter_reload}, 32'h3A);
        read_check("rd_reload_lo", A_RELOAD_LO, 4'hA);
        read_check("rd_reload_hi", A_RELOAD_HI, 4'h3);

        // Writes to read-only addresses leave everything untouched
        do_write(A_DATA_LO, 4'hF);
        do_write(A_FACTOR, 4'hF);
        check_val("ro_write", {24'd0, timer_counter_reload}, 32'h3A);

        // Coherent count read
        timer_downcounter = 8'h5C;
        read_check("rd_data_lo", A_DATA_LO, 4'hC);
        timer_downcounter = 8'h4F;
        read_check("rd_data_hi_latched", A_DATA_HI, 4'h5);
        read_check("rd_data_lo2", A_DATA_LO, 4'hF);
        read_check("rd_data_hi2", A_DATA_HI, 4'h4);

        // CTRL: run plus a single reload pulse
        do_write(A_CTRL, 4'b0011);
        check_val("ctrl_enable", {31'd0, timer_enable}, 32'd1);
        check_val("ctrl_pulse", {31'd0, timer_reset}, 32'd1);
        @(posedge clk);
        #1;
        check_val("ctrl_pulse_end", {31'd0, timer_reset}, 32'd0);
        read_check("rd_ctrl", A_CTRL, 4'h1);

        // Back-to-back reload pulses
        @(negedge clk);
        bus.bus_addr       = A_CTRL;
        bus.bus_write_data = 4'b1110;
        bus.bus_write_en   = 1'b1;
        @(posedge clk);
        #1;
        check_val("b2b_pulse1", {31'd0, timer_reset}, 32'd1);
        @(posedge clk);
        #1;
        bus.bus_write_en   = 1'b0;
        check_val("b2b_pulse2", {31'd0, timer_reset}, 32'd1);
        check_val("b2b_enable_off", {31'd0, timer_enable}, 32'd0);
        @(posedge clk);
        #1;
        check_val("b2b_pulse_end", {31'd0, timer_reset}, 32'd0);
        read_check("rd_ctrl0", A_CTRL, 4'h0);

        // Clock select keeps three bits
        do_write(A_CLKSEL, 4'hF);
        check_val("clksel", {29'd0, timer_clock_selection}, 32'd7);
        read_check("rd_clksel", A_CLKSEL, 4'h7);

        // Interrupt path
        do_write(A_MASK, 4'h1);
        read_check("rd_mask", A_MASK, 4'h1);
        @(negedge clk);
        timer_factor_flags = 1'b1;
        #1;
        check_val("irq_not_yet", {31'd0, interrupt_req}, 32'd0);
        @(posedge clk);
        #1;
        check_val("irq_set", {31'd0, interrupt_req}, 32'd1);
        read_check("rd_factor1", A_FACTOR, 4'h1);
        check_val("rfactor_pulse", {31'd0, timer_reset_factor}, 32'd1);
        @(posedge clk);
        #1;
        check_val("rfactor_end", {31'd0, timer_reset_factor}, 32'd0);
        @(negedge clk);
        timer_factor_flags = 1'b0;
        read_check("rd_factor0", A_FACTOR, 4'h0);
        check_val("rfactor_none", {31'd0, timer_reset_factor}, 32'd0);
        check_val("irq_drop_factor", {31'd0, interrupt_req}, 32'd0);

        @(negedge clk);
        timer_factor_flags = 1'b1;
        @(posedge clk);
        #1;
        check_val("irq_set2", {31'd0, interrupt_req}, 32'd1);
        do_write(A_MASK, 4'h0);
        @(posedge clk);
        #1;
        check_val("irq_drop_mask", {31'd0, interrupt_req}, 32'd0);
        do_write(A_MASK, 4'h1);

        // Same-cycle read and write returns the old value
        @(negedge clk);
        bus.bus_addr       = A_RELOAD_LO;
        bus.bus_write_data = 4'h5;
        bus.bus_write_en   = 1'b1;
        bus.bus_read_en    = 1'b1;
        @(posedge clk);
        #1;
        bus.bus_write_en   = 1'b0;
        bus.bus_read_en    = 1'b0;
        check_val("rw_old_value", {28'd0, bus.bus_read_data}, 32'hA);
        check_val("rw_write_applied", {24'd0, timer_counter_reload}, 32'h35);

        // Reset during a pending factor-clear pulse
        read_check("rd_factor_pre_rst", A_FACTOR, 4'h1);
        check_val("rfactor_pending", {31'd0, timer_reset_factor}, 32'd1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_val("rst_kills_rfactor", {31'd0, timer_reset_factor}, 32'd0);
        check_val("rst_mask_irq", {31'd0, interrupt_req}, 32'd0);
        timer_factor_flags = 1'b0;

        // Reset during a pending reload pulse
        do_write(A_RELOAD_HI, 4'h9);
        do_write(A_MASK, 4'h1);
        do_write(A_CTRL, 4'b0011);
        check_val("treset_pending", {31'd0, timer_reset}, 32'd1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_val("rst_kills_treset", {31'd0, timer_reset}, 32'd0);
        check_val("rst_clr_enable", {31'd0, timer_enable}, 32'd0);
        check_val("rst_clr_reload", {24'd0, timer_counter_reload}, 32'd0);
        check_val("rst_clr_clksel", {29'd0, timer_clock_selection}, 32'd0);
        read_check("rst_clr_mask", A_MASK, 4'h0);
        read_check("rst_clr_hi_latch", A_DATA_HI, 4'h0);

        // Reset wins over a coincident write
        @(negedge clk);
        reset_n            = 1'b0;
        bus.bus_addr       = A_CTRL;
        bus.bus_write_data = 4'b0011;
        bus.bus_write_en   = 1'b1;
        @(posedge clk);
        #1;
        bus.bus_write_en   = 1'b0;
        reset_n            = 1'b1;
        check_val("rst_prio_enable", {31'd0, timer_enable}, 32'd0);
        check_val("rst_prio_treset", {31'd0, timer_reset}, 32'd0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
